// File: rtl/freelist.sv
// Physical-register freelist: circular buffer of free pregs with dual allocate, dual release
// and a committed head pointer that flush rolls back to.
module freelist #(
    parameter int unsigned NUM_PREG = 64,
    parameter int unsigned NUM_LREG = 32,
    parameter int unsigned FL_SIZE  = NUM_PREG - NUM_LREG,
    localparam int unsigned FL_LOG  = $clog2(FL_SIZE),
    localparam int unsigned PW      = $clog2(NUM_PREG)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              alloc0_req,
    input  logic              alloc1_req,
    output logic [PW-1:0]     alloc0_preg,
    output logic [PW-1:0]     alloc1_preg,
    output logic              alloc_ready,
    input  logic              commit0_valid,
    input  logic              commit1_valid,
    input  logic              commit0_need_to_wb,
    input  logic              commit1_need_to_wb,
    input  logic [PW-1:0]     commit0_old_prd,
    input  logic [PW-1:0]     commit1_old_prd,
    input  logic              flush_valid,
    output logic [FL_LOG:0]   free_count,
    output logic              overflow_err
);

    // Pointers carry the wrap flag in the MSB so plain subtraction yields the occupancy.
    logic [PW-1:0]   entry_q [FL_SIZE];
    logic [FL_LOG:0] head_q, head_d;
    logic [FL_LOG:0] tail_q, tail_d;
    logic [FL_LOG:0] arch_head_q, arch_head_d;
    logic            overflow_q;

    logic [FL_LOG-1:0] head_idx, head_p1_idx, tail_idx, wr0_idx, wr1_idx;
    logic              fire0, fire1, rel0, rel1, acc0, acc1;
    logic [1:0]        n_alloc, n_rel, n_acc;
    logic [FL_LOG+1:0] room;

    always_comb begin
        free_count  = tail_q - head_q;
        alloc_ready = (free_count >= (FL_LOG+1)'(2));

        head_idx    = head_q[FL_LOG-1:0];
        head_p1_idx = head_idx + 1'b1;
        tail_idx    = tail_q[FL_LOG-1:0];

        alloc0_preg = entry_q[head_idx];
        alloc1_preg = alloc0_req ? entry_q[head_p1_idx] : entry_q[head_idx];

        fire0   = alloc0_req & alloc_ready & ~flush_valid;
        fire1   = alloc1_req & alloc_ready & ~flush_valid;
        n_alloc = {1'b0, fire0} + {1'b0, fire1};

        // Commit is in-order: a younger release without the older commit is dropped.
        rel0  = commit0_valid & commit0_need_to_wb;
        rel1  = commit1_valid & commit0_valid & commit1_need_to_wb;
        n_rel = {1'b0, rel0} + {1'b0, rel1};

        // Slots vacated by this cycle's allocations count as room for this cycle's releases.
        room = (FL_LOG+2)'(FL_SIZE) - (FL_LOG+2)'(free_count) + (FL_LOG+2)'(n_alloc);
        acc0 = rel0 & (room >= (FL_LOG+2)'(1));
        acc1 = rel1 & (room >= (acc0 ? (FL_LOG+2)'(2) : (FL_LOG+2)'(1)));
        n_acc = {1'b0, acc0} + {1'b0, acc1};

        wr0_idx = tail_idx;
        wr1_idx = acc0 ? tail_idx + 1'b1 : tail_idx;

        arch_head_d = arch_head_q + (FL_LOG+1)'(n_rel);
        head_d      = flush_valid ? arch_head_d : head_q + (FL_LOG+1)'(n_alloc);
        tail_d      = tail_q + (FL_LOG+1)'(n_acc);

        overflow_err = overflow_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < FL_SIZE; i++) begin
                entry_q[i] <= PW'(NUM_LREG + i);
            end
            head_q      <= '0;
            tail_q      <= (FL_LOG+1)'(FL_SIZE);
            arch_head_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            if (acc0) entry_q[wr0_idx] <= commit0_old_prd;
            if (acc1) entry_q[wr1_idx] <= commit1_old_prd;
            head_q      <= head_d;
            tail_q      <= tail_d;
            arch_head_q <= arch_head_d;
            if ((rel0 & ~acc0) | (rel1 & ~acc1)) overflow_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_freelist.sv
// Scoreboard bench for freelist: a queue model of free and in-flight pregs predicts every
// allocation, occupancy and the sticky overflow flag.
module tb_freelist;

    localparam int PW = 6;
    localparam int FL = 32;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          alloc0_req = 0, alloc1_req = 0;
    logic [PW-1:0] alloc0_preg, alloc1_preg;
    logic          alloc_ready;
    logic          commit0_valid = 0, commit1_valid = 0;
    logic          commit0_need_to_wb = 0, commit1_need_to_wb = 0;
    logic [PW-1:0] commit0_old_prd = '0, commit1_old_prd = '0;
    logic          flush_valid = 0;
    logic [5:0]    free_count;
    logic          overflow_err;

    freelist dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .alloc0_req         (alloc0_req),
        .alloc1_req         (alloc1_req),
        .alloc0_preg        (alloc0_preg),
        .alloc1_preg        (alloc1_preg),
        .alloc_ready        (alloc_ready),
        .commit0_valid      (commit0_valid),
        .commit1_valid      (commit1_valid),
        .commit0_need_to_wb (commit0_need_to_wb),
        .commit1_need_to_wb (commit1_need_to_wb),
        .commit0_old_prd    (commit0_old_prd),
        .commit1_old_prd    (commit1_old_prd),
        .flush_valid        (flush_valid),
        .free_count         (free_count),
        .overflow_err       (overflow_err)
    );

    always #5 clock = ~clock;

    int  n_vec = 0;
    int  n_err = 0;
    int  fl_m[$];
    int  infl_m[$];
    int  exp_q[$];
    bit  ovf_m;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        fl_m.delete();
        infl_m.delete();
        exp_q.delete();
        for (int i = 0; i < FL; i++) fl_m.push_back(32 + i);
        ovf_m = 1'b0;
    endfunction

    task automatic clear_inputs();
        alloc0_req = 0; alloc1_req = 0;
        commit0_valid = 0; commit1_valid = 0;
        commit0_need_to_wb = 0; commit1_need_to_wb = 0;
        commit0_old_prd = '0; commit1_old_prd = '0;
        flush_valid = 0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        clear_inputs();
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
    endtask

    // One clock: drive at negedge, compare mid-cycle, advance model, wait for the edge.
    task automatic cycle(input bit a0, input bit a1, input bit c0v, input bit c0w, input int c0p,
                         input bit c1v, input bit c1w, input int c1p, input bit fl);
        bit ready, f0, f1, r0, r1;
        int room, n_al, n_rel, v0, v1;
        @(negedge clock);
        alloc0_req = a0; alloc1_req = a1;
        commit0_valid = c0v; commit0_need_to_wb = c0w; commit0_old_prd = c0p[PW-1:0];
        commit1_valid = c1v; commit1_need_to_wb = c1w; commit1_old_prd = c1p[PW-1:0];
        flush_valid = fl;
        #1;
        ready = (fl_m.size() >= 2);
        check_eq("free_count", free_count, fl_m.size());
        check_eq("alloc_ready", alloc_ready, ready);
        check_eq("overflow_err", overflow_err, ovf_m);
        f0 = a0 & ready & ~fl;
        f1 = a1 & ready & ~fl;
        if (f0) exp_q.push_back(fl_m[0]);
        if (f1) exp_q.push_back(a0 ? fl_m[1] : fl_m[0]);
        if (f0) check_eq("alloc0_preg", alloc0_preg, exp_q.pop_front());
        else if (fl_m.size() >= 1) check_eq("alloc0_head", alloc0_preg, fl_m[0]);
        if (f1) check_eq("alloc1_preg", alloc1_preg, exp_q.pop_front());

        r0 = c0v & c0w;
        r1 = c1v & c0v & c1w;
        n_al = int'(f0) + int'(f1);
        n_rel = int'(r0) + int'(r1);
        room = FL - fl_m.size() + n_al;
        repeat (n_rel) if (infl_m.size() > 0) void'(infl_m.pop_front());
        v0 = fl_m.size() > 0 ? fl_m[0] : 0;
        v1 = a0 ? (fl_m.size() > 1 ? fl_m[1] : 0) : v0;
        if (f0) begin void'(fl_m.pop_front()); infl_m.push_back(v0); end
        if (f1) begin void'(fl_m.pop_front()); infl_m.push_back(v1); end
        if (r0) begin
            if (room >= 1) begin fl_m.push_back(c0p); room--; end
            else ovf_m = 1'b1;
        end
        if (r1) begin
            if (room >= 1) begin fl_m.push_back(c1p); room--; end
            else ovf_m = 1'b1;
        end
        if (fl) begin
            fl_m = {infl_m, fl_m};
            infl_m.delete();
        end
        @(posedge clock);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit a0, a1, c0v, c0w, c1v, c1w, fl;
        int c0p, c1p, k;
        model_reset();
        #12 reset_n = 1'b1;

        // Reset values, then a dual allocation
        idle();
        cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
        idle();

        // Younger slot alone takes the head
        do_reset();
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle();

        // Drain to two, then allocate the last two while releasing one
        do_reset();
        repeat (15) cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 1, 1, 5, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
        idle();

        // Two committed writers plus flush rolls head back to the committed position
        do_reset();
        repeat (2) cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 1, 1, 1, 1, 2, 1);
        idle();

        // Release into a full list
        do_reset();
        cycle(0, 0, 1, 1, 7, 0, 0, 0, 0);
        idle();
        idle();

        // Steady single alloc/release stream wraps both pointers
        do_reset();
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 34; i++) cycle(1, 0, 1, 1, infl_m[0], 0, 0, 0, 0);
        idle();

        // commit1 without commit0 must not release
        cycle(0, 0, 0, 0, 0, 1, 1, 9, 0);
        idle();

        // Randomised traffic with conserving releases and occasional flush
        for (int i = 0; i < 300; i++) begin
            a0 = 1'($urandom_range(0, 1));
            a1 = 1'($urandom_range(0, 1));
            fl = ($urandom_range(0, 15) == 0);
            k = 0;
            c0v = 0; c0w = 0; c0p = 0; c1v = 0; c1w = 0; c1p = 0;
            if (infl_m.size() > 0 && $urandom_range(0, 2) != 0) begin
                c0v = 1;
                c0w = ($urandom_range(0, 3) != 0);
                if (c0w) begin c0p = infl_m[0]; k = 1; end
                if (infl_m.size() > k && $urandom_range(0, 1) == 1) begin
                    c1v = 1;
                    c1w = 1;
                    c1p = infl_m[k];
                end
            end
            cycle(a0, a1, c0v, c0w, c0p, c1v, c1w, c1p, fl);
        end

        // Reset asserted mid-cycle with alloc and release in flight
        repeat (3) cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        alloc0_req = 1; alloc1_req = 1;
        commit0_valid = 1; commit0_need_to_wb = 1; commit0_old_prd = 6'd3;
        #2 reset_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        clear_inputs();
        reset_n = 1'b1;
        model_reset();
        idle();
        cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/freelist.md
FREELIST -- requirements
Module: freelist

Interface
REQ-001 SHALL have parameter NUM_PREG, default 64, number of physical registers.
REQ-002 SHALL have parameter NUM_LREG, default 32, number of logical registers; pregs 0..NUM_LREG-1 are architecturally mapped at reset.
REQ-003 SHALL have parameter FL_SIZE = NUM_PREG-NUM_LREG, default 32, freelist depth (power of two); FL_LOG = log2(FL_SIZE); PW = log2(NUM_PREG).
REQ-004 SHALL have port: clock, input, 1, clock; all state on rising edge.
REQ-005 SHALL have port: reset_n, input, 1, asynchronous, active-low reset.
REQ-006 SHALL have ports: alloc0_req, alloc1_req, input, 1 each, rename slot requests a new preg (slot 1 younger).
REQ-007 SHALL have ports: alloc0_preg, alloc1_preg, output, PW each, allocated preg per slot.
REQ-008 SHALL have port: alloc_ready, output, 1, freelist can serve two allocations this cycle.
REQ-009 SHALL have ports: commit0_valid, commit1_valid, input, 1 each, ROB commit of oldest / second-oldest instruction.
REQ-010 SHALL have ports: commit0_need_to_wb, commit1_need_to_wb, input, 1 each, committing instruction allocated a preg.
REQ-011 SHALL have ports: commit0_old_prd, commit1_old_prd, input, PW each, preg to release.
REQ-012 SHALL have port: flush_valid, input, 1, squash all uncommitted allocations.
REQ-013 SHALL have port: free_count, output, FL_LOG+1, pregs currently in list.
REQ-014 SHALL have port: overflow_err, output, 1, sticky release-into-full error.

Function
REQ-015 SHALL store FL_SIZE entries of PW bits in a circular buffer with head (read) and tail (write) pointers, each FL_LOG bits plus wrap flag.
REQ-016 SHALL keep arch_head pointer (FL_LOG+flag): head position as of last committed allocation.
REQ-017 SHALL compute free_count = {tail_flag,tail} - {head_flag,head} mod 2^(FL_LOG+1); flags equal and indices equal = empty, flags differ and indices equal = full (FL_SIZE).
REQ-018 SHALL drive alloc_ready = (free_count >= 2), combinational from registered state.
REQ-019 SHALL drive alloc0_preg = entry[head]; alloc1_preg = entry[head+1] if alloc0_req else entry[head]; zero-latency, index wraps mod FL_SIZE.
REQ-020 SHALL fire alloc_i only when alloc_i_req & alloc_ready & ~flush_valid; head advances by fired count (0/1/2) next edge, flag toggles on wrap.
REQ-021 SHALL ignore requests while alloc_ready=0; upstream holds until ready.
REQ-022 SHALL release commit_i when commit_i_valid & commit_i_need_to_wb; releases written at tail, tail+1 in slot order; tail advances by release count.
REQ-023 SHALL ignore commit1 release if commit1_valid with commit0_valid=0 (illegal; commit is in-order).
REQ-024 SHALL advance arch_head by release count each cycle (each committing writer consumed one entry).
REQ-025 SHALL, on flush_valid, load head <= arch_head_next (arch_head plus same-cycle releases); same-cycle commits still processed; same-cycle allocations suppressed.
REQ-026 SHALL use pre-update free_count for alloc_ready; same-cycle releases visible next cycle.
REQ-027 SHALL set overflow_err when releases would make free_count exceed FL_SIZE; excess write dropped, tail saturates; cleared only by reset.
REQ-028 SHALL NOT check preg uniqueness; duplicate release is an upstream bug.

Reset
REQ-029 SHALL on reset_n low set entry[i] = NUM_LREG+i, head=0/flag0, tail=0/flag1 (full), arch_head=0/flag0, overflow_err=0.
REQ-030 SHALL after reset present free_count=FL_SIZE, alloc_ready=1, alloc0_preg=NUM_LREG, alloc1_preg=NUM_LREG+1 (with alloc0_req).
REQ-031 SHALL abandon in-flight alloc/release on reset assertion mid-operation; no partial update survives.

Verification
REQ-032 Reset, both req one cycle -> alloc0_preg=32, alloc1_preg=33; next cycle free_count=30, alloc0_preg=34.
REQ-033 Only alloc1_req after reset -> alloc1_preg=32, head+1; next alloc0_preg=33.
REQ-034 Allocate 30 (free_count=2), then commit0 release old_prd=5 with dual alloc same cycle -> allocs 62,63 served; next cycle free_count=1, alloc_ready=0, entry[0]=5.
REQ-035 Allocate 4 (32..35), commit 2 writers releasing 1,2, flush -> head=arch_head=2 (flag0), tail=2 (flag0) so free_count=0? no: releases raise tail to 2 flag1 -> free_count=32, alloc0_preg=34.
REQ-036 After reset, commit0 release old_prd=7 while full -> overflow_err=1 next cycle, free_count stays 32.
REQ-037 Allocate 34 cycles of 1 with matching releases -> head/tail wrap, flags toggle, free_count steady, alloc preg sequence continues from released values in order.
